// File: rtl/alt_s1_sched.sv
// Round-robin scheduler that shares one s1 engine among N_REQ requesters.
// It handles one job at a time and returns the engine result, an error flag and a timeout flag.
module alt_s1_sched #(
   parameter int N_REQ   = 4,
   parameter int TMO_CYC = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [N_REQ*21-1:0]  i_nv,
   input  logic [N_REQ*25-1:0]  i_nu,
   input  logic [N_REQ*21-1:0]  i_no,
   output logic [N_REQ-1:0]     o_gnt,
   output logic [N_REQ-1:0]     o_rsp_vld,
   output logic [31:0]          o_s1,
   output logic                 o_s1_error,
   output logic                 o_tmo,
   output logic                 o_busy,
   output logic [15:0]          o_err_cnt,
   input  logic                 i_clr_cnt,
   output logic                 o_start,
   output logic [20:0]          o_nv,
   output logic [24:0]          o_nu,
   output logic [20:0]          o_no,
   input  logic                 i_s1_busy,
   input  logic [31:0]          i_s1,
   input  logic                 i_s1_vld,
   input  logic                 i_s1_error
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TMO_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [IDX_W-1:0]  cur_q, cur_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       s1_q, s1_d;
   logic              s1_err_q, s1_err_d;
   logic              tmo_q, tmo_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [20:0]       nv_q, nv_d;
   logic [24:0]       nu_q, nu_d;
   logic [20:0]       no_q, no_d;

   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  cand;
   logic              found;
   logic              grant_ok;
   logic [20:0]       nv_sel;
   logic [24:0]       nu_sel;
   logic [20:0]       no_sel;

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (idx == LAST_IDX) return '0;
      return idx + 1'b1;
   endfunction

   // Round-robin search starting just after the last served requester.
   always_comb begin
      win_idx = last_q;
      found   = 1'b0;
      cand    = next_idx(last_q);
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && i_req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
         cand = next_idx(cand);
      end
   end

   always_comb begin
      nv_sel = '0;
      nu_sel = '0;
      no_sel = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_idx == IDX_W'(k)) begin
            nv_sel = i_nv[k*21 +: 21];
            nu_sel = i_nu[k*25 +: 25];
            no_sel = i_no[k*21 +: 21];
         end
      end
   end

   // Gated by rst so no grant pulse is visible while reset is held.
   assign grant_ok = rst && (state_q == S_IDLE) && !i_s1_busy && found;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cur_d     = cur_q;
      cnt_d     = cnt_q;
      s1_d      = s1_q;
      s1_err_d  = s1_err_q;
      tmo_d     = tmo_q;
      err_cnt_d = err_cnt_q;
      nv_d      = nv_q;
      nu_d      = nu_q;
      no_d      = no_q;
      case (state_q)
         S_IDLE: begin
            if (grant_ok) begin
               cur_d   = win_idx;
               nv_d    = nv_sel;
               nu_d    = nu_sel;
               no_d    = no_sel;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (i_s1_vld) begin
               s1_d     = i_s1;
               s1_err_d = i_s1_error;
               tmo_d    = 1'b0;
               state_d  = S_DONE;
            end else if (cnt_q == CNT_MAX) begin
               s1_d     = '0;
               s1_err_d = 1'b1;
               tmo_d    = 1'b1;
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            last_d = cur_q;
            if (s1_err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (i_clr_cnt) err_cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         last_q    <= LAST_IDX;
         cur_q     <= '0;
         cnt_q     <= '0;
         s1_q      <= '0;
         s1_err_q  <= 1'b0;
         tmo_q     <= 1'b0;
         err_cnt_q <= '0;
         nv_q      <= '0;
         nu_q      <= '0;
         no_q      <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cur_q     <= cur_d;
         cnt_q     <= cnt_d;
         s1_q      <= s1_d;
         s1_err_q  <= s1_err_d;
         tmo_q     <= tmo_d;
         err_cnt_q <= err_cnt_d;
         nv_q      <= nv_d;
         nu_q      <= nu_d;
         no_q      <= no_d;
      end
   end

   always_comb begin
      o_gnt     = '0;
      o_rsp_vld = '0;
      for (int k = 0; k < N_REQ; k++) begin
         o_gnt[k]     = grant_ok && (win_idx == IDX_W'(k));
         o_rsp_vld[k] = (state_q == S_DONE) && (cur_q == IDX_W'(k));
      end
   end

   assign o_start    = (state_q == S_START);
   assign o_busy     = (state_q != S_IDLE);
   assign o_s1       = s1_q;
   assign o_s1_error = s1_err_q;
   assign o_tmo      = tmo_q;
   assign o_err_cnt  = err_cnt_q;
   assign o_nv       = nv_q;
   assign o_nu       = nu_q;
   assign o_no       = no_q;

endmodule

// File: tb/tb_alt_s1_sched.sv
// Testbench for alt_s1_sched: random jobs are checked against a round-robin/timing model.
// The model tracks the last served requester, the expected result registers and the error count.
module tb_alt_s1_sched;

   localparam int N   = 4;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    i_req = '0;
   logic [N*21-1:0] i_nv = '0;
   logic [N*25-1:0] i_nu = '0;
   logic [N*21-1:0] i_no = '0;
   logic [N-1:0]    o_gnt, o_rsp_vld;
   logic [31:0]     o_s1;
   logic            o_s1_error, o_tmo, o_busy, o_start;
   logic [15:0]     o_err_cnt;
   logic            i_clr_cnt = 1'b0;
   logic [20:0]     o_nv, o_no;
   logic [24:0]     o_nu;
   logic            i_s1_busy = 1'b0;
   logic [31:0]     i_s1 = '0;
   logic            i_s1_vld = 1'b0;
   logic            i_s1_error = 1'b0;

   int checks = 0;
   int errors = 0;

   int          last_srv  = N - 1;
   int          err_model = 0;
   logic [31:0] exp_s1    = '0;
   logic        exp_err   = 1'b0;
   logic        exp_tmo   = 1'b0;

   always #5 clk = ~clk;

   alt_s1_sched #(.N_REQ(N), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_nv(i_nv), .i_nu(i_nu), .i_no(i_no),
      .o_gnt(o_gnt), .o_rsp_vld(o_rsp_vld), .o_s1(o_s1), .o_s1_error(o_s1_error),
      .o_tmo(o_tmo), .o_busy(o_busy), .o_err_cnt(o_err_cnt), .i_clr_cnt(i_clr_cnt),
      .o_start(o_start), .o_nv(o_nv), .o_nu(o_nu), .o_no(o_no), .i_s1_busy(i_s1_busy),
      .i_s1(i_s1), .i_s1_vld(i_s1_vld), .i_s1_error(i_s1_error)
   );

   function automatic int rr_pick(input logic [N-1:0] req, input int last);
      for (int i = 1; i <= N; i++) begin
         if (req[(last + i) % N]) return (last + i) % N;
      end
      return 0;
   endfunction

   task automatic rand_ops();
      i_nv = 84'({$urandom, $urandom, $urandom});
      i_nu = 100'({$urandom, $urandom, $urandom, $urandom});
      i_no = 84'({$urandom, $urandom, $urandom});
   endtask

   // One full job: optional busy hold-off, grant, start, engine response after dly cycles
   // (dly = 0 means the engine never answers), response and return to idle.
   task automatic do_job(input logic [N-1:0] req, input int busy_cyc, input int dly,
                         input logic [31:0] s1, input logic err, input bit clr);
      int          w, lat, exp_lat;
      bit          seen;
      logic [N-1:0] exp_g;
      logic [20:0] env, eno;
      logic [24:0] enu;
      @(posedge clk); #1;
      i_req     = req;
      i_s1_busy = (busy_cyc > 0);
      for (int c = 0; c < busy_cyc; c++) begin
         #1;
         checks++;
         if (o_gnt !== '0) begin
            errors++;
            $display("FAIL busy_holdoff: o_gnt=%b required 0", o_gnt);
         end
         @(posedge clk); #1;
      end
      i_s1_busy = 1'b0;
      #1;
      w     = rr_pick(req, last_srv);
      exp_g = N'(1) << w;
      env   = 21'(i_nv >> (21 * w));
      enu   = 25'(i_nu >> (25 * w));
      eno   = 21'(i_no >> (21 * w));
      checks++;
      if (o_gnt !== exp_g) begin
         errors++;
         $display("FAIL grant: o_gnt=%b required %b (req=%b)", o_gnt, exp_g, req);
      end

      @(posedge clk); #1;
      rand_ops();
      #1;
      checks++;
      if (o_start !== 1'b1 || o_gnt !== '0 || o_busy !== 1'b1 ||
          {o_nv, o_nu, o_no} !== {env, enu, eno}) begin
         errors++;
         $display("FAIL start: start=%b gnt=%b busy=%b nv=%0d nu=%0d no=%0d required 1 0 1 %0d %0d %0d",
                  o_start, o_gnt, o_busy, o_nv, o_nu, o_no, env, enu, eno);
      end

      exp_lat = (dly == 0) ? TMO + 1 : dly + 1;
      seen = 1'b0;
      lat  = 0;
      for (int c = 1; c <= TMO + 4 && !seen; c++) begin
         @(posedge clk); #1;
         i_s1_vld   = (dly == c);
         i_s1       = (dly == c) ? s1 : $urandom;
         i_s1_error = (dly == c) ? err : 1'($urandom);
         i_clr_cnt  = clr && (c == exp_lat);
         #1;
         if (o_rsp_vld !== '0) begin
            seen = 1'b1;
            lat  = c;
         end
      end
      checks++;
      if (!seen || lat != exp_lat) begin
         errors++;
         $display("FAIL rsp_latency: got %0d cycles (seen=%0d) required %0d", lat, seen, exp_lat);
      end

      if (dly == 0) begin
         exp_s1 = '0; exp_err = 1'b1; exp_tmo = 1'b1;
      end else begin
         exp_s1 = s1; exp_err = err; exp_tmo = 1'b0;
      end
      checks++;
      if (o_rsp_vld !== exp_g || o_s1 !== exp_s1 || o_s1_error !== exp_err || o_tmo !== exp_tmo) begin
         errors++;
         $display("FAIL response: rsp=%b s1=%h err=%b tmo=%b required %b %h %b %b",
                  o_rsp_vld, o_s1, o_s1_error, o_tmo, exp_g, exp_s1, exp_err, exp_tmo);
      end

      last_srv = w;
      if (clr) err_model = 0;
      else if (exp_err && err_model < 65535) err_model++;

      @(posedge clk); #1;
      i_req = '0; i_s1_vld = 1'b0; i_clr_cnt = 1'b0;
      #1;
      checks++;
      if (o_busy !== 1'b0 || o_rsp_vld !== '0 || o_err_cnt !== 16'(err_model) || o_s1 !== exp_s1 ||
          o_s1_error !== exp_err || o_tmo !== exp_tmo) begin
         errors++;
         $display("FAIL back_to_idle: busy=%b rsp=%b err_cnt=%0d s1=%h required 0 0 %0d %h",
                  o_busy, o_rsp_vld, o_err_cnt, o_s1, err_model, exp_s1);
      end
   endtask

   task automatic test_reset();
      i_req = 4'b1000;
      rand_ops();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({o_gnt, o_rsp_vld, o_start, o_s1, o_s1_error, o_tmo, o_busy, o_err_cnt, o_nv, o_nu, o_no} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: gnt=%b start=%b busy=%b s1=%h err_cnt=%0d required all 0",
                  o_gnt, o_start, o_busy, o_s1, o_err_cnt);
      end
      rst   = 1'b1;
      i_req = '0;
   endtask

   task automatic test_single();
      rand_ops();
      i_nv[20:0] = 21'd1000;
      i_nu[24:0] = 25'd50000;
      i_no[20:0] = 21'd200;
      do_job(4'b0001, 0, 6, 32'h0000_1234, 1'b0, 1'b0);
   endtask

   task automatic test_round_robin();
      int exp_order[5] = '{0, 1, 2, 3, 0};
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      last_srv = N - 1; err_model = 0; exp_s1 = '0; exp_err = 1'b0; exp_tmo = 1'b0;
      for (int j = 0; j < 5; j++) begin
         rand_ops();
         checks++;
         if (rr_pick(4'b1111, last_srv) != exp_order[j]) begin
            errors++;
            $display("FAIL rr_order_model: job %0d winner %0d required %0d", j, rr_pick(4'b1111, last_srv), exp_order[j]);
         end
         do_job(4'b1111, 0, $urandom_range(1, TMO), $urandom, 1'b0, 1'b0);
      end
   endtask

   task automatic test_timeout();
      rand_ops();
      do_job(4'b0100, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
   endtask

   task automatic test_vld_at_timeout();
      rand_ops();
      do_job(4'b0010, 0, TMO, 32'hCAFE_0001, 1'b0, 1'b0);
   endtask

   task automatic test_engine_error();
      rand_ops();
      do_job(4'b1000, 0, 3, 32'h0, 1'b1, 1'b0);
      rand_ops();
      do_job(4'b0001, 0, 2, 32'h0, 1'b1, 1'b1);
   endtask

   task automatic test_busy_holdoff();
      rand_ops();
      do_job(4'b0010, 4, 5, 32'h5555_AAAA, 1'b0, 1'b0);
   endtask

   task automatic test_vld_ignored();
      @(posedge clk); #1;
      i_s1_vld = 1'b1; i_s1 = 32'hFFFF_0000 ^ exp_s1; i_s1_error = ~exp_err;
      @(posedge clk); #1;
      i_s1_vld = 1'b0;
      #1;
      checks++;
      if (o_s1 !== exp_s1 || o_s1_error !== exp_err || o_tmo !== exp_tmo || o_busy !== 1'b0 || o_rsp_vld !== '0) begin
         errors++;
         $display("FAIL vld_ignored: s1=%h err=%b tmo=%b busy=%b rsp=%b required %h %b %b 0 0",
                  o_s1, o_s1_error, o_tmo, o_busy, o_rsp_vld, exp_s1, exp_err, exp_tmo);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] req;
      int           dly;
      for (int j = 0; j < 20; j++) begin
         req = N'($urandom_range(1, (1 << N) - 1));
         dly = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TMO);
         rand_ops();
         do_job(req, $urandom_range(0, 2), dly, $urandom, 1'($urandom), ($urandom_range(0, 4) == 0));
      end
   endtask

   task automatic test_reset_mid_wait();
      rand_ops();
      @(posedge clk); #1;
      i_req = 4'b0100;
      @(posedge clk); #1;
      i_req = '0;
      repeat (2) @(posedge clk);
      #1;
      rst   = 1'b0;
      i_req = 4'b1000;
      for (int c = 0; c < 2; c++) begin
         #1;
         checks++;
         if ({o_gnt, o_rsp_vld, o_start, o_s1, o_s1_error, o_tmo, o_busy, o_err_cnt, o_nv, o_nu, o_no} !== '0) begin
            errors++;
            $display("FAIL reset_mid_wait: gnt=%b rsp=%b start=%b busy=%b s1=%h err_cnt=%0d required all 0",
                     o_gnt, o_rsp_vld, o_start, o_busy, o_s1, o_err_cnt);
         end
         i_s1_vld = (c == 1);
         @(posedge clk); #1;
      end
      i_s1_vld = 1'b0;
      rst = 1'b1;
      last_srv = N - 1; err_model = 0; exp_s1 = '0; exp_err = 1'b0; exp_tmo = 1'b0;
      #1;
      checks++;
      if (o_gnt !== 4'b1000 || o_rsp_vld !== '0) begin
         errors++;
         $display("FAIL grant_after_reset: gnt=%b rsp=%b required 1000 0000", o_gnt, o_rsp_vld);
      end
      i_req = '0;
      do_job(4'b1000, 0, 4, 32'h0BAD_F00D, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_vld_at_timeout();
      test_engine_error();
      test_busy_holdoff();
      test_vld_ignored();
      test_random();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
